if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port clk_in, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_in, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port rdy_in, input, 1, global enable; when 0, all state holds.
REQ-004 SHALL have port jump_flag, input, 1, redirect request from execute.
REQ-005 SHALL have port jump_target, input, 32, redirect PC; bits [1:0] ignored (treated as 0).
REQ-006 SHALL have port stall_in, input, 1, decode busy; 1 means the instruction is not accepted this cycle.
REQ-007 SHALL have port mem_busy, input, 1, data-side access owns the memory; no fetch issue allowed.
REQ-008 SHALL have port mem_din, input, 8, byte returned one cycle after its request.
REQ-009 SHALL have port mem_req, output, 1, byte read request (combinational from registered state and mem_busy).
REQ-010 SHALL have port mem_addr, output, 32, byte address of the request; 0 when mem_req=0.
REQ-011 SHALL have port pc, output, 32, registered address of the current instruction.
REQ-012 SHALL have port ins, output, 32, registered assembled instruction word.
REQ-013 SHALL have port ins_valid, output, 1, registered; ins and pc are valid for decode.

Function
REQ-014 SHALL have two states: FETCH (collecting bytes) and VALID (holding a complete word).
REQ-015 SHALL keep 3-bit counters issue_cnt and recv_cnt (0..4) and a 1-bit pending flag.
REQ-016 In FETCH, with issue_cnt<4, mem_busy=0 and jump_flag=0, SHALL assert mem_req with mem_addr=pc+issue_cnt (mod 2^32), increment issue_cnt and set pending.
REQ-017 In FETCH with mem_busy=1, SHALL assert no request; issue_cnt holds.
REQ-018 When pending=1 at a clock edge, SHALL latch mem_din into ins[8*recv_cnt+7 : 8*recv_cnt] (little-endian) and increment recv_cnt; pending is cleared unless a new request issues in the same cycle.
REQ-019 The capture in REQ-018 SHALL occur regardless of mem_busy, since the byte was already issued.
REQ-020 When recv_cnt reaches 4, SHALL enter VALID with ins_valid=1 on the next cycle; the best-case latency from entering FETCH to ins_valid=1 is 5 cycles.
REQ-021 In VALID, SHALL hold pc, ins and ins_valid=1 while stall_in=1, and issue no requests.
REQ-022 In VALID with stall_in=0, SHALL treat the word as accepted: next cycle ins_valid=0, pc=pc+4 (wraps 0xFFFFFFFC to 0x00000000), counters cleared, state FETCH.
REQ-023 jump_flag=1 in any state SHALL take priority over every other event. The next cycle SHALL have pc={jump_target[31:2],2'b00}, ins_valid=0, counters=0, pending=0, state FETCH.
REQ-024 On a jump, no request SHALL issue in the jump cycle. A byte returning the cycle after the jump (from a request issued before it) SHALL be discarded.
REQ-025 A jump coinciding with an accepted transfer (VALID, stall_in=0) SHALL still redirect to jump_target and not to pc+4.
REQ-026 With rdy_in=0, SHALL hold all registers and force mem_req=0. rdy_in has lower priority than rst_in.
REQ-027 ins SHALL only change on byte capture; stale upper bytes are permitted while ins_valid=0.

Reset
REQ-028 With rst_in=1 at a clock edge, SHALL set pc=0, ins=0, ins_valid=0, issue_cnt=0, recv_cnt=0, pending=0, state FETCH. mem_req SHALL be 0 during that cycle.
REQ-029 Reset mid-fetch SHALL discard in-flight bytes. The first request after reset deasserts SHALL be address 0x00000000.

Verification
REQ-030 Reset, memory bytes 0x13,0x05,0x10,0x00 at addresses 0..3, mem_busy=0, stall_in=0 -> requests to addresses 0,1,2,3 on consecutive cycles; ins_valid=1 with ins=0x00100513, pc=0; the next request is address 4.
REQ-031 mem_busy=1 for 3 cycles after the second issue -> no mem_req during those cycles; the second byte is still captured; the word completes 3 cycles late and is correct.
REQ-032 VALID with stall_in=1 for 4 cycles -> pc, ins and ins_valid stable, mem_req=0. stall_in=0 -> next cycle ins_valid=0, first request to pc+4.
REQ-033 jump_flag=1, jump_target=0x00001002 while issue_cnt=2 -> next cycle pc=0x00001000; the returning byte is ignored; requests to 0x1000..0x1003; the assembled word contains only new-address bytes.
REQ-034 pc=0xFFFFFFFC accepted -> pc=0x00000000 and the first request is address 0x00000000.
REQ-035 rdy_in=0 for 2 cycles mid-fetch -> counters, ins and pc frozen, mem_req=0; fetch resumes with the correct next address.

Source files
------------

// File: rtl/if_stage_if.sv
// Byte-wide instruction memory port between the fetch stage and the memory arbiter.
//   mem_req  : byte read request (driven by fetch)
//   mem_addr : byte address of the request, 0 when idle (driven by fetch)
//   mem_din  : byte returned one cycle after its request (driven by memory)
//   mem_busy : data-side access owns memory, no fetch issue allowed (driven by memory)
interface if_stage_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_busy;

  modport master (output mem_req, output mem_addr, input mem_din, input mem_busy);
  modport slave  (input mem_req, input mem_addr, output mem_din, output mem_busy);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: assembles a 32-bit little-endian word from four byte
// reads, presents it to decode with pc/ins_valid, and handles redirects.
// Ports:
//   clk_in      : clock, all state changes on rising edge
//   rst_in      : synchronous active-high reset
//   rdy_in      : global enable, 0 freezes all state and suppresses requests
//   jump_flag   : redirect request from execute (highest priority)
//   jump_target : redirect PC, bits [1:0] ignored
//   stall_in    : decode busy, the held word is not accepted this cycle
//   mem         : byte memory port (master side)
//   pc          : address of the current instruction
//   ins         : assembled instruction word
//   ins_valid   : ins/pc valid for decode
module if_stage (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        jump_flag,
  input  logic [31:0] jump_target,
  input  logic        stall_in,
  if_stage_if.master  mem,
  output logic [31:0] pc,
  output logic [31:0] ins,
  output logic        ins_valid
);
  localparam int unsigned XLEN           = 32;
  localparam int unsigned CNT_W          = 3;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic {ST_FETCH = 1'b0, ST_VALID = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   ins_q, ins_d;
  logic              ins_valid_q, ins_valid_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  recv_cnt_q, recv_cnt_d;
  logic              pending_q, pending_d;
  logic              issue_c;

  // A byte request goes out only while fetching, enabled, and with memory free.
  assign issue_c = rdy_in && !rst_in && !jump_flag && !mem.mem_busy &&
                   (state_q == ST_FETCH) &&
                   (issue_cnt_q < CNT_W'(BYTES_PER_WORD));

  assign mem.mem_req  = issue_c;
  assign mem.mem_addr = issue_c ? (pc_q + XLEN'(issue_cnt_q)) : '0;

  // Next-state logic; everything holds when rdy_in is low.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ins_d       = ins_q;
    ins_valid_d = ins_valid_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    pending_d   = pending_q;

    if (rdy_in) begin
      if (jump_flag) begin
        // Redirect wins over capture/accept; an in-flight byte is dropped.
        state_d     = ST_FETCH;
        pc_d        = {jump_target[XLEN-1:2], 2'b00};
        ins_valid_d = 1'b0;
        issue_cnt_d = '0;
        recv_cnt_d  = '0;
        pending_d   = 1'b0;
      end else begin
        unique case (state_q)
          ST_FETCH: begin
            // Capture is independent of mem_busy: the byte was already issued.
            if (pending_q) begin
              ins_d[{recv_cnt_q[1:0], 3'b000} +: 8] = mem.mem_din;
              recv_cnt_d = recv_cnt_q + CNT_W'(1);
            end
            pending_d = issue_c;
            if (issue_c) begin
              issue_cnt_d = issue_cnt_q + CNT_W'(1);
            end
            if (recv_cnt_d == CNT_W'(BYTES_PER_WORD)) begin
              state_d     = ST_VALID;
              ins_valid_d = 1'b1;
            end
          end
          ST_VALID: begin
            if (!stall_in) begin
              state_d     = ST_FETCH;
              pc_d        = pc_q + XLEN'(BYTES_PER_WORD);
              ins_valid_d = 1'b0;
              issue_cnt_d = '0;
              recv_cnt_d  = '0;
              pending_d   = 1'b0;
            end
          end
          default: state_d = ST_FETCH;
        endcase
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      ins_q       <= '0;
      ins_valid_q <= 1'b0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ins_q       <= ins_d;
      ins_valid_q <= ins_valid_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      pending_q   <= pending_d;
    end
  end

  assign pc        = pc_q;
  assign ins       = ins_q;
  assign ins_valid = ins_valid_q;
endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        jump = 1'b0;
  logic [31:0] jt = 32'h0;
  logic        stall = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] ins_o;
  logic        valid_o;
  logic [7:0]  din_q = 8'h00;

  int total = 0;
  int bad   = 0;

  if_stage_if bus ();

  if_stage dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .rdy_in      (rdy),
    .jump_flag   (jump),
    .jump_target (jt),
    .stall_in    (stall),
    .mem         (bus.master),
    .pc          (pc_o),
    .ins         (ins_o),
    .ins_valid   (valid_o)
  );

  always #5 clk = ~clk;

  // Memory: first word is 0x00100513, elsewhere a[7:0]^a[15:8]^0xA5.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ 8'hA5;
    endcase
  endfunction

  // Byte returns one cycle after its request and holds until the next one.
  always @(posedge clk) if (bus.mem_req) din_q <= mem_byte(bus.mem_addr);
  assign bus.mem_din = din_q;

  typedef struct {
    logic        rst, rdy, jump;
    logic [31:0] jt;
    logic        stall, busy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        chk_regs;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic        chk_ins;
    logic [31:0] exp_ins;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic b,
                     input logic req, input logic [31:0] addr,
                     input logic cr, input logic [31:0] p, input logic v,
                     input logic ci, input logic [31:0] w);
    vec_t x;
    x.rst = r; x.rdy = 1'b1; x.jump = 1'b0; x.jt = 32'h0;
    x.stall = s; x.busy = b; x.exp_req = req; x.exp_addr = addr;
    x.chk_regs = cr; x.exp_pc = p; x.exp_valid = v; x.chk_ins = ci; x.exp_ins = w;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then let outputs settle.
  task automatic cyc(input logic r, input logic e, input logic j, input logic [31:0] t,
                     input logic s, input logic b);
    @(negedge clk);
    rst = r; rdy = e; jump = j; jt = t; stall = s; bus.mem_busy = b;
    #2;
  endtask

  task automatic exp_req(input string n, input logic req, input logic [31:0] addr);
    chk({n, ".req"}, 32'(bus.mem_req), 32'(req));
    chk({n, ".addr"}, bus.mem_addr, addr);
  endtask

  task automatic exp_st(input string n, input logic [31:0] p, input logic v);
    chk({n, ".pc"}, pc_o, p);
    chk({n, ".valid"}, 32'(valid_o), 32'(v));
  endtask

  initial begin
    bus.mem_busy = 1'b0;

    // Basic fetch, stall hold, accept (r s b | req addr | cr pc v | ci ins)
    add(1,0,0, 0,32'h0, 0,32'h0,0, 0,32'h0);
    add(0,0,0, 1,32'h0, 1,32'h0,0, 1,32'h0);
    add(0,0,0, 1,32'h1, 1,32'h0,0, 0,32'h0);
    add(0,0,0, 1,32'h2, 1,32'h0,0, 0,32'h0);
    add(0,0,0, 1,32'h3, 1,32'h0,0, 0,32'h0);
    add(0,0,0, 0,32'h0, 1,32'h0,0, 0,32'h0);
    for (int i = 0; i < 4; i++)
      add(0,1,0, 0,32'h0, 1,32'h0,1, 1,32'h00100513);
    add(0,0,0, 0,32'h0, 1,32'h0,1, 1,32'h00100513);
    add(0,0,0, 1,32'h4, 1,32'h4,0, 0,32'h0);
    add(0,0,0, 1,32'h5, 1,32'h4,0, 0,32'h0);
    add(0,0,0, 1,32'h6, 1,32'h4,0, 0,32'h0);
    add(0,0,0, 1,32'h7, 1,32'h4,0, 0,32'h0);
    add(0,0,0, 0,32'h0, 1,32'h4,0, 0,32'h0);
    add(0,0,0, 0,32'h0, 1,32'h4,1, 1,32'hA2A3A0A1);
    add(0,0,0, 1,32'h8, 1,32'h8,0, 0,32'h0);
    // mem_busy for 3 cycles after the second issue
    add(1,0,0, 0,32'h0, 0,32'h0,0, 0,32'h0);
    add(0,0,0, 1,32'h0, 1,32'h0,0, 1,32'h0);
    add(0,0,0, 1,32'h1, 1,32'h0,0, 0,32'h0);
    for (int i = 0; i < 3; i++)
      add(0,0,1, 0,32'h0, 1,32'h0,0, 0,32'h0);
    add(0,0,0, 1,32'h2, 1,32'h0,0, 0,32'h0);
    add(0,0,0, 1,32'h3, 1,32'h0,0, 0,32'h0);
    add(0,0,0, 0,32'h0, 1,32'h0,0, 0,32'h0);
    add(0,0,0, 0,32'h0, 1,32'h0,1, 1,32'h00100513);
    add(0,0,0, 1,32'h4, 1,32'h4,0, 0,32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      string n;
      n = $sformatf("vec%0d", i);
      cyc(vecs[i].rst, vecs[i].rdy, vecs[i].jump, vecs[i].jt, vecs[i].stall, vecs[i].busy);
      exp_req(n, vecs[i].exp_req, vecs[i].exp_addr);
      if (vecs[i].chk_regs) exp_st(n, vecs[i].exp_pc, vecs[i].exp_valid);
      if (vecs[i].chk_ins) chk({n, ".ins"}, ins_o, vecs[i].exp_ins);
    end

    // Jump at issue_cnt=2, then jump during accept, then pc wrap
    cyc(1,1,0,32'h0,0,0);
    cyc(0,1,0,32'h0,0,0); exp_req("j0", 1, 32'h0);
    cyc(0,1,0,32'h0,0,0); exp_req("j1", 1, 32'h1);
    cyc(0,1,1,32'h00001002,0,0); exp_req("jcyc", 0, 32'h0); exp_st("jcyc", 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0,1,0,32'h0,0,0);
      exp_req($sformatf("jf%0d", i), 1, 32'h1000 + 32'(i));
      exp_st($sformatf("jf%0d", i), 32'h1000, 0);
    end
    cyc(0,1,0,32'h0,0,0); exp_req("jdrain", 0, 32'h0);
    cyc(0,1,0,32'h0,1,0); exp_st("jword", 32'h1000, 1); chk("jword.ins", ins_o, 32'hB6B7B4B5);
    exp_req("jword", 0, 32'h0);
    cyc(0,1,1,32'hFFFFFFFF,0,0); exp_req("jacc", 0, 32'h0); exp_st("jacc", 32'h1000, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0,1,0,32'h0,0,0);
      exp_req($sformatf("wf%0d", i), 1, 32'hFFFFFFFC + 32'(i));
      exp_st($sformatf("wf%0d", i), 32'hFFFFFFFC, 0);
    end
    cyc(0,1,0,32'h0,0,0);
    cyc(0,1,0,32'h0,0,0); exp_st("wword", 32'hFFFFFFFC, 1); chk("wword.ins", ins_o, 32'hA5A4A7A6);
    cyc(0,1,0,32'h0,0,0); exp_st("wrap", 32'h0, 0); exp_req("wrap", 1, 32'h0);

    // rdy_in low for 2 cycles mid-fetch
    cyc(1,1,0,32'h0,0,0);
    cyc(0,1,0,32'h0,0,0); exp_req("r0", 1, 32'h0);
    cyc(0,1,0,32'h0,0,0); exp_req("r1", 1, 32'h1);
    for (int i = 0; i < 2; i++) begin
      cyc(0,0,0,32'h0,0,0);
      exp_req($sformatf("rfrz%0d", i), 0, 32'h0);
      exp_st($sformatf("rfrz%0d", i), 32'h0, 0);
    end
    cyc(0,1,0,32'h0,0,0); exp_req("r2", 1, 32'h2);
    cyc(0,1,0,32'h0,0,0); exp_req("r3", 1, 32'h3);
    cyc(0,1,0,32'h0,0,0); exp_req("rdrain", 0, 32'h0);
    cyc(0,1,0,32'h0,1,0); exp_st("rword", 32'h0, 1); chk("rword.ins", ins_o, 32'h00100513);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
